// File: rtl/kacc_pkg.sv
// Shared constants and helpers for the FP16 Kulisch carry-save accumulator datapath.
package kacc_pkg;

    localparam int NUM    = 4;
    localparam int WWIDTH = 79;
    localparam int VWIDTH = 12;
    localparam int AWIDTH = WWIDTH + VWIDTH;
    localparam int IWIDTH = WWIDTH;
    localparam int BIAS   = 15;

    function automatic logic [AWIDTH-1:0] sext_to_acc(input logic [IWIDTH-1:0] x);
        return {{(AWIDTH-IWIDTH){x[IWIDTH-1]}}, x};
    endfunction

    // Carry vector of a full-adder row, already shifted into its weight position.
    function automatic logic [AWIDTH-1:0] csa_carry(input logic [AWIDTH-1:0] a,
                                                    input logic [AWIDTH-1:0] b,
                                                    input logic [AWIDTH-1:0] c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

endpackage

// File: rtl/csa_compress_tree.sv
// Combinational Wallace-style 3:2 reduction of N W-bit operands down to a sum/carry pair.
module csa_compress_tree #(
    parameter int N = 8,
    parameter int W = 91
) (
    input  logic [N*W-1:0] ops,
    output logic [W-1:0]   sum_o,
    output logic [W-1:0]   carry_o
);

    logic [W-1:0] row [N+2];
    logic [W-1:0] nxt [N+2];
    int           cnt;
    int           ncnt;
    int           grp_end;

    // Each level turns every complete triple into two vectors and passes leftovers through;
    // the two spare slots keep the i+1/i+2 reads in range.
    always_comb begin
        for (int i = 0; i < N + 2; i++) row[i] = '0;
        for (int i = 0; i < N; i++) row[i] = ops[i*W +: W];
        cnt     = N;
        ncnt    = 0;
        grp_end = 0;
        for (int lvl = 0; lvl < N; lvl++) begin
            for (int i = 0; i < N + 2; i++) nxt[i] = '0;
            ncnt    = 0;
            grp_end = (cnt > 2) ? 3 * (cnt / 3) : 0;
            for (int i = 0; i < N; i++) begin
                if (i < grp_end) begin
                    if (i % 3 == 0) begin
                        nxt[ncnt]     = row[i] ^ row[i+1] ^ row[i+2];
                        nxt[ncnt + 1] = ((row[i] & row[i+1]) | (row[i] & row[i+2]) |
                                         (row[i+1] & row[i+2])) << 1;
                        ncnt = ncnt + 2;
                    end
                end else if (i < cnt) begin
                    nxt[ncnt] = row[i];
                    ncnt      = ncnt + 1;
                end
            end
            for (int i = 0; i < N + 2; i++) row[i] = nxt[i];
            cnt = ncnt;
        end
        sum_o   = row[0];
        carry_o = row[1];
    end

endmodule

// File: rtl/kulisch_csa_acc_pipe.sv
// Three-stage carry-save Kulisch accumulator: compress lanes, fold into acc, resolve with one CPA.
module kulisch_csa_acc_pipe
    import kacc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_first,
    input  logic                   i_last,
    input  logic [NUM*IWIDTH-1:0]  i_sum,
    input  logic [NUM*IWIDTH-1:0]  i_carry,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [AWIDTH-1:0]      o_acc,
    output logic                   o_ovf
);

    localparam int NOPS = 2 * NUM;

    logic [NOPS*AWIDTH-1:0] ops;
    logic [AWIDTH-1:0]      tree_s, tree_c;
    logic                   adv;

    logic              s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
    logic [AWIDTH-1:0] s1_s_q, s1_s_d, s1_c_q, s1_c_d;
    logic [AWIDTH-1:0] acc_s_q, acc_s_d, acc_c_q, acc_c_d;
    logic              s2_v_q, s2_v_d;
    logic [AWIDTH-1:0] o_acc_q, o_acc_d;
    logic              o_ovf_q, o_ovf_d, o_valid_q, o_valid_d;

    logic [AWIDTH-1:0]   base_s, base_c, row_x, row_y, resolved;
    logic [AWIDTH-WWIDTH:0] top_bits;

    always_comb begin
        ops = '0;
        for (int k = 0; k < NUM; k++) begin
            ops[k*AWIDTH +: AWIDTH]       = sext_to_acc(i_sum[k*IWIDTH +: IWIDTH]);
            ops[(NUM+k)*AWIDTH +: AWIDTH] = sext_to_acc(i_carry[k*IWIDTH +: IWIDTH]);
        end
    end

    csa_compress_tree #(
        .N (NOPS),
        .W (AWIDTH)
    ) u_tree (
        .ops     (ops),
        .sum_o   (tree_s),
        .carry_o (tree_c)
    );

    // A held result freezes the whole pipe, so every stage shares one enable.
    always_comb begin
        adv = !o_valid_q || i_ready;

        s1_v_d     = i_valid;
        s1_first_d = i_first;
        s1_last_d  = i_last;
        s1_s_d     = tree_s;
        s1_c_d     = tree_c;

        base_s  = s1_first_q ? '0 : acc_s_q;
        base_c  = s1_first_q ? '0 : acc_c_q;
        row_x   = base_s ^ base_c ^ s1_s_q;
        row_y   = csa_carry(base_s, base_c, s1_s_q);
        acc_s_d = acc_s_q;
        acc_c_d = acc_c_q;
        if (s1_v_q) begin
            acc_s_d = row_x ^ row_y ^ s1_c_q;
            acc_c_d = csa_carry(row_x, row_y, s1_c_q);
        end
        s2_v_d = s1_v_q && s1_last_q;

        // Overflow means the guard bits plus the WWIDTH sign bit are not a pure sign extension.
        resolved  = acc_s_q + acc_c_q;
        top_bits  = resolved[AWIDTH-1:WWIDTH-1];
        o_acc_d   = o_acc_q;
        o_ovf_d   = o_ovf_q;
        if (s2_v_q) begin
            o_acc_d = resolved;
            o_ovf_d = !((&top_bits) || (~|top_bits));
        end
        o_valid_d = s2_v_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_s_q     <= '0;
            s1_c_q     <= '0;
            acc_s_q    <= '0;
            acc_c_q    <= '0;
            s2_v_q     <= 1'b0;
            o_acc_q    <= '0;
            o_ovf_q    <= 1'b0;
            o_valid_q  <= 1'b0;
        end else if (adv) begin
            s1_v_q     <= s1_v_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            s1_s_q     <= s1_s_d;
            s1_c_q     <= s1_c_d;
            acc_s_q    <= acc_s_d;
            acc_c_q    <= acc_c_d;
            s2_v_q     <= s2_v_d;
            o_acc_q    <= o_acc_d;
            o_ovf_q    <= o_ovf_d;
            o_valid_q  <= o_valid_d;
        end
    end

    assign o_ready = adv;
    assign o_valid = o_valid_q;
    assign o_acc   = o_acc_q;
    assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_kulisch_csa_acc_pipe.sv
// Directed bench for kulisch_csa_acc_pipe with a result scoreboard checked at every output handshake.
module tb_kulisch_csa_acc_pipe;
    import kacc_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_valid, i_first, i_last, i_ready;
    logic [NUM*IWIDTH-1:0] i_sum, i_carry;
    logic                  o_ready, o_valid, o_ovf;
    logic [AWIDTH-1:0]     o_acc;

    int                checks = 0;
    int                errors = 0;
    int                cycle  = 0;
    logic [AWIDTH-1:0] expAcc [$];
    logic              expOvf [$];
    int                hsCycle [$];

    kulisch_csa_acc_pipe dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_first (i_first),
        .i_last  (i_last),
        .i_sum   (i_sum),
        .i_carry (i_carry),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_acc   (o_acc),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [AWIDTH-1:0] got,
                               input logic [AWIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM*IWIDTH-1:0] pack4(input logic [IWIDTH-1:0] a,
                                                    input logic [IWIDTH-1:0] b,
                                                    input logic [IWIDTH-1:0] c,
                                                    input logic [IWIDTH-1:0] d);
        return {d, c, b, a};
    endfunction

    // Holds a beat on the bus until the edge that accepts it; returns just after that edge.
    task automatic applyStimulus(input logic first, input logic last,
                                 input logic [NUM*IWIDTH-1:0] sum,
                                 input logic [NUM*IWIDTH-1:0] carry);
        bit accepted = 1'b0;
        int waitCnt  = 0;
        i_valid = 1'b1;
        i_first = first;
        i_last  = last;
        i_sum   = sum;
        i_carry = carry;
        while (!accepted && waitCnt < 50) begin
            @(negedge clk);
            accepted = o_ready;
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (!accepted) checkOutput("accept_timeout", 0, 1);
    endtask

    // Idle bus carries junk control and data that must be ignored.
    task automatic idleBus();
        i_valid = 1'b0;
        i_first = 1'b1;
        i_last  = 1'b1;
        i_sum   = pack4(79'd99, 79'd98, 79'd97, 79'd96);
        i_carry = pack4(79'd55, 79'd54, 79'd53, 79'd52);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (expAcc.size() != 0 && n < 40) begin
            waitCycles(1);
            n++;
        end
        checkOutput("drain_pending", expAcc.size(), 0);
        waitCycles(2);
    endtask

    initial begin
        logic [AWIDTH-1:0] ea;
        logic              eo;
        forever begin
            @(negedge clk);
            if (!rst && o_valid && i_ready) begin
                hsCycle.push_back(cycle);
                if (expAcc.size() == 0) begin
                    checkOutput("unexpected_result", 1, 0);
                end else begin
                    ea = expAcc.pop_front();
                    eo = expOvf.pop_front();
                    checkOutput("result_acc", o_acc, ea);
                    checkOutput("result_ovf", o_ovf, eo);
                end
            end
        end
    end

    initial begin
        logic [IWIDTH-1:0] m1;
        logic [IWIDTH-1:0] p77;
        logic [AWIDTH-1:0] e;

        rst     = 1'b1;
        i_ready = 1'b1;
        idleBus();
        waitCycles(3);
        checkOutput("rst_valid", o_valid, 0);
        checkOutput("rst_acc", o_acc, 0);
        checkOutput("rst_ovf", o_ovf, 0);
        checkOutput("rst_ready", o_ready, 1);
        rst = 1'b0;
        waitCycles(1);

        // Single beat of four unit lanes and its latency.
        expAcc.push_back(91'd4); expOvf.push_back(1'b0);
        applyStimulus(1, 1, pack4(1, 1, 1, 1), '0);
        idleBus();
        checkOutput("t1_lat_e1", o_valid, 0);
        waitCycles(1);
        checkOutput("t1_lat_e2", o_valid, 0);
        waitCycles(1);
        checkOutput("t1_lat_e3", o_valid, 1);
        drain();

        // Eight operands of -1 give -8.
        m1 = '1;
        e  = '1;
        e  = e - 91'd7;
        expAcc.push_back(e); expOvf.push_back(1'b0);
        applyStimulus(1, 1, pack4(m1, m1, m1, m1), pack4(m1, m1, m1, m1));
        idleBus();
        drain();

        // Three-beat dot product, a back-to-back single beat, then a chained continuation.
        hsCycle.delete();
        expAcc.push_back(91'd30); expOvf.push_back(1'b0);
        expAcc.push_back(91'd5);  expOvf.push_back(1'b0);
        expAcc.push_back(91'd11); expOvf.push_back(1'b0);
        applyStimulus(1, 0, pack4(1, 2, 3, 0), pack4(0, 0, 0, 4));
        applyStimulus(0, 0, pack4(4, 0, 0, 0), pack4(3, 3, 0, 0));
        applyStimulus(0, 1, pack4(2, 2, 2, 2), pack4(1, 1, 0, 0));
        applyStimulus(1, 1, pack4(5, 0, 0, 0), '0);
        applyStimulus(0, 1, pack4(0, 0, 0, 6), '0);
        idleBus();
        drain();
        checkOutput("t3_count", hsCycle.size(), 3);
        if (hsCycle.size() == 3) begin
            checkOutput("t3_b2b_a", hsCycle[1] - hsCycle[0], 1);
            checkOutput("t3_b2b_b", hsCycle[2] - hsCycle[1], 1);
        end

        // Downstream stall while beats keep arriving.
        i_ready = 1'b0;
        for (int v = 11; v <= 14; v++) begin
            expAcc.push_back(AWIDTH'(v)); expOvf.push_back(1'b0);
        end
        fork
            begin
                for (int v = 11; v <= 14; v++)
                    applyStimulus(1, 1, pack4(IWIDTH'(v), 0, 0, 0), '0);
                idleBus();
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!o_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput("t4_valid_seen", o_valid, 1);
                for (int c = 0; c < 5; c++) begin
                    checkOutput("t4_hold_acc", o_acc, 11);
                    checkOutput("t4_ready_low", o_ready, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        drain();

        // Two beats of 2^78 overflow the 79-bit signed range.
        p77      = '0;
        p77[77]  = 1'b1;
        e        = '0;
        e[79]    = 1'b1;
        expAcc.push_back(e); expOvf.push_back(1'b1);
        applyStimulus(1, 0, pack4(p77, 0, 0, 0), pack4(p77, 0, 0, 0));
        idleBus();
        waitCycles(2);
        applyStimulus(0, 1, pack4(p77, 0, 0, 0), pack4(p77, 0, 0, 0));
        idleBus();
        drain();

        // Reset in the middle of a dot product drops everything in flight.
        applyStimulus(1, 0, pack4(1, 0, 0, 0), '0);
        applyStimulus(0, 0, pack4(1, 0, 0, 0), '0);
        idleBus();
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("t6_rst_valid", o_valid, 0);
        checkOutput("t6_rst_acc", o_acc, 0);
        checkOutput("t6_rst_ovf", o_ovf, 0);
        for (int c = 0; c < 4; c++) begin
            waitCycles(1);
            checkOutput("t6_no_valid", o_valid, 0);
        end
        expAcc.push_back(91'd7); expOvf.push_back(1'b0);
        applyStimulus(0, 1, pack4(7, 0, 0, 0), '0);
        expAcc.push_back(91'd7); expOvf.push_back(1'b0);
        applyStimulus(1, 1, pack4(3, 0, 0, 0), pack4(4, 0, 0, 0));
        idleBus();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
